// File: rtl/mem_port_sequencer.sv
// Arbitrates one fixed-latency synchronous memory port between instruction fetch and data load/store.
// It raises a pipeline-wide stall while any request is pending and never replays a request that has already been served.
module mem_port_sequencer #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_rmem,
  input  logic          d_wmem,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [CW-1:0] CNT_LAT = CW'(LAT);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          d_served, if_served;
  logic          d_pend, i_pend, d_go, i_go;
  logic          is_wr;
  logic          launch_d, launch_i, fin_d, fin_i, abort_i;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // A request whose done pulse is showing this cycle is complete, so it neither stalls nor relaunches.
  always_comb begin
    d_pend   = (d_rmem | d_wmem) & ~d_served;
    i_pend   = if_req & ~if_served & ~if_flush;
    d_go     = d_pend & ~d_done;
    i_go     = i_pend & ~if_done;
    stall    = d_go | i_go;
    state_d  = state;
    cnt_d    = cnt;
    launch_d = 1'b0;
    launch_i = 1'b0;
    fin_d    = 1'b0;
    fin_i    = 1'b0;
    abort_i  = 1'b0;
    mem_en   = (state != IDLE);
    mem_we   = (state == BUSY_D) && is_wr && (cnt == CNT_LAT);
    case (state)
      IDLE: begin
        if (d_go) begin
          state_d  = BUSY_D;
          cnt_d    = CNT_LAT;
          launch_d = 1'b1;
        end else if (i_go) begin
          state_d  = BUSY_I;
          cnt_d    = CNT_LAT;
          launch_i = 1'b1;
        end
      end
      BUSY_D: begin
        if (cnt == '0) begin
          state_d = IDLE;
          fin_d   = 1'b1;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      BUSY_I: begin
        if (if_flush) begin
          state_d = IDLE;
          abort_i = 1'b1;
        end else if (cnt == '0) begin
          state_d = IDLE;
          fin_i   = 1'b1;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      d_served  <= 1'b0;
      if_served <= 1'b0;
      is_wr     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      d_rdata   <= '0;
      if_rdata  <= '0;
      d_done    <= 1'b0;
      if_done   <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      d_done  <= fin_d;
      if_done <= fin_i;
      if (launch_d) begin
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        is_wr     <= d_wmem;
      end
      if (launch_i) mem_addr <= if_addr;
      if (fin_d && !is_wr) d_rdata <= mem_rdata;
      if (fin_i) if_rdata <= mem_rdata;
      // Served flags only matter while the pipeline stays frozen on the same instruction pair.
      if (!stall) begin
        d_served  <= 1'b0;
        if_served <= 1'b0;
      end else begin
        if (d_done)  d_served  <= 1'b1;
        if (if_done) if_served <= 1'b1;
        if (abort_i) if_served <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Testbench for mem_port_sequencer: directed cases plus random request mixes.
// A transaction-level model predicts completion timing, port activity and the data returned for each step.
module tb_mem_port_sequencer;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, d_rmem, d_wmem;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_done, d_done, stall, mem_en, mem_we;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] pipe    [LAT];
  logic [15:0] cyc = '0;
  logic [31:0] exp_d, exp_i;

  mem_port_sequencer #(.AW(32), .DW(32), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_done(if_done),
    .d_rmem(d_rmem), .d_wmem(d_wmem), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .stall(stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Fixed-latency memory; data not belonging to an enabled read is junk.
  always @(posedge clk) begin
    cyc <= cyc + 16'd1;
    if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    pipe[0] <= mem_en ? mem[mem_addr[9:2]] : {16'hA5A5, cyc};
    for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
  end
  assign mem_rdata = pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drop_inputs();
    if_req = 0; if_flush = 0; d_rmem = 0; d_wmem = 0;
  endtask

  // One frozen instruction pair: requests held until every expected completion is seen.
  task automatic run_step(input bit rd, input bit wr, input bit fe,
                          input logic [31:0] da, input logic [31:0] dw,
                          input logic [31:0] ia, input string tag);
    int d_at = -1, i_at = -1, en_n = 0, we_n = 0, st_n = 0, n, last, e_d_at, e_i_at;
    logic [31:0] we_a = '0, we_d = '0, got_d = '0, got_i = '0;
    bit has_d;
    has_d  = rd | wr;
    n      = int'(has_d) + int'(fe);
    last   = n * (LAT + 2);
    e_d_at = has_d ? LAT + 2 : -1;
    e_i_at = fe ? n * (LAT + 2) : -1;
    if (wr) ref_mem[da[9:2]] = dw;
    else if (rd) exp_d = ref_mem[da[9:2]];
    if (fe) exp_i = ref_mem[ia[9:2]];
    @(negedge clk);
    d_rmem = rd; d_wmem = wr; d_addr = da; d_wdata = dw;
    if_req = fe; if_addr = ia; if_flush = 0;
    #1;
    for (int k = 0; k <= last + 6; k++) begin
      if (stall) st_n++;
      if (mem_en) en_n++;
      if (mem_we) begin we_n++; we_a = mem_addr; we_d = mem_wdata; end
      if (d_done && d_at < 0) begin d_at = k; got_d = d_rdata; end
      if (if_done && i_at < 0) begin i_at = k; got_i = if_rdata; end
      if (k >= last && (d_at >= 0 || !has_d) && (i_at >= 0 || !fe)) break;
      @(negedge clk); #1;
    end
    drop_inputs();
    @(negedge clk); #1;
    chk({tag, "_idle_stall"}, 32'(stall), 32'd0);
    chk({tag, "_idle_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_d_done_at"}, d_at, e_d_at);
    chk({tag, "_if_done_at"}, i_at, e_i_at);
    chk({tag, "_en_cycles"}, en_n, n * (LAT + 1));
    chk({tag, "_stall_cycles"}, st_n, last);
    chk({tag, "_we_cycles"}, we_n, wr ? 1 : 0);
    if (wr) begin
      chk({tag, "_we_addr"}, we_a, da);
      chk({tag, "_we_data"}, we_d, dw);
    end
    if (rd && !wr) chk({tag, "_d_rdata_at_done"}, got_d, exp_d);
    if (fe) chk({tag, "_if_rdata_at_done"}, got_i, exp_i);
    chk({tag, "_d_rdata"}, d_rdata, exp_d);
    chk({tag, "_if_rdata"}, if_rdata, exp_i);
  endtask

  initial begin
    int nd;
    logic [31:0] v;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    exp_d = '0; exp_i = '0;
    rst = 1; drop_inputs(); if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ctrl", {27'd0, if_done, d_done, stall, mem_en, mem_we}, 0);
    rst = 0;

    run_step(1, 0, 0, 32'h10, 32'h0, 32'h0, "load");
    run_step(0, 1, 0, 32'h20, 32'h12345678, 32'h0, "store");
    run_step(1, 0, 1, 32'h20, 32'h0, 32'h40, "both");

    // Flush in the second fetch cycle.
    @(negedge clk); if_req = 1; if_addr = 32'h44; #1;
    chk("flush_req_stall", 32'(stall), 1);
    @(negedge clk); #1;
    chk("flush_busy_en", 32'(mem_en), 1);
    @(negedge clk); if_flush = 1; #1;
    chk("flush_stall", 32'(stall), 0);
    @(negedge clk); drop_inputs(); #1;
    chk("flush_idle_en", 32'(mem_en), 0);
    nd = int'(if_done);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      nd += int'(if_done);
    end
    chk("flush_no_done", nd, 0);
    chk("flush_keep_if_rdata", if_rdata, exp_i);
    run_step(0, 0, 1, 32'h0, 32'h0, 32'h48, "refetch");

    // Reset in the middle of a load.
    @(negedge clk); d_rmem = 1; d_addr = 32'h30; #1;
    @(negedge clk); #1;
    @(negedge clk); rst = 1; drop_inputs(); #1;
    @(negedge clk); rst = 0; #1;
    chk("midrst_ctrl", {27'd0, if_done, d_done, stall, mem_en, mem_we}, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_wdata", mem_wdata, 0);
    chk("midrst_d_rdata", d_rdata, 0);
    chk("midrst_if_rdata", if_rdata, 0);
    exp_d = '0; exp_i = '0;
    @(negedge clk); #1;
    chk("midrst_no_done", 32'(d_done), 0);
    run_step(1, 0, 0, 32'h30, 32'h0, 32'h0, "post_rst_load");

    run_step(1, 1, 0, 32'h50, 32'hCAFEF00D, 32'h0, "rd_wr_store");
    run_step(1, 0, 0, 32'h50, 32'h0, 32'h0, "readback");

    for (int s = 0; s < 30; s++) begin
      run_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               {22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom,
               {22'd0, 8'($urandom_range(0, 255)), 2'b00}, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
